lcd_bus_reader: RTL and testbench

Read-side master for the 8080-style parallel LCD bus that drives `ARDUINO_IO[13:0]`. It issues one command byte (D/C low, WR strobe) and then reads 0–4 data bytes with RD strobes, returning them as one word. It shares the bus with the screen write path through a request/grant pair, and is used for panel ID and status readback.

---
 rtl/lcd_bus_reader_if.sv | 31 +++
 rtl/lcd_bus_reader.sv | 136 +++++++++++++
 tb/tb_lcd_bus_reader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_reader_if.sv
// Signal bundle between the LCD read master and its user/bus side.
// master = reader block, slave = requester plus panel bus/arbiter.
interface lcd_bus_reader_if;
  logic        start;
  logic [7:0]  cmd;
  logic [2:0]  num_bytes;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rd_data;
  logic        bus_req;
  logic        bus_grant;
  logic [7:0]  lcd_db_out;
  logic [7:0]  lcd_db_in;
  logic        lcd_db_oe;
  logic        lcd_wr;
  logic        lcd_rd;
  logic        lcd_d_c;

  modport master (
    input  start, cmd, num_bytes, bus_grant, lcd_db_in,
    output busy, done, err, rd_data, bus_req,
    output lcd_db_out, lcd_db_oe, lcd_wr, lcd_rd, lcd_d_c
  );

  modport slave (
    output start, cmd, num_bytes, bus_grant, lcd_db_in,
    input  busy, done, err, rd_data, bus_req,
    input  lcd_db_out, lcd_db_oe, lcd_wr, lcd_rd, lcd_d_c
  );
endinterface

// File: rtl/lcd_bus_reader.sv
// 8080-style LCD read master: one command write, then 0..MAX_BYTES RD strobes.
// All outputs are registered from the next-state decode so they move only on clk.
module lcd_bus_reader #(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int RD_LOW_CYC  = 10,
  parameter int RD_HIGH_CYC = 4,
  parameter int MAX_BYTES   = 4
) (
  input logic              clk,
  input logic              reset,
  lcd_bus_reader_if.master lcd
);

  localparam int CNT_W  = 8;
  localparam int LEFT_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CMD_LOW, S_CMD_HIGH, S_TURN, S_RD_LOW, S_RD_HIGH, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt, w_len;
  logic [LEFT_W-1:0]   r_left, w_left_next, w_nb;
  logic [7:0]          r_cmd;
  logic [31:0]         r_rd_data;
  logic                w_last, w_abort, w_capture, w_accept, w_on_bus;
  logic                r_busy, r_done, r_err, r_bus_req;
  logic                r_wr, r_rd, r_d_c, r_oe;
  logic [7:0]          r_db_out;

  assign w_accept = (r_state == S_IDLE) && lcd.start;
  assign w_nb     = (int'(lcd.num_bytes) > MAX_BYTES) ? LEFT_W'(MAX_BYTES)
                                                      : LEFT_W'(lcd.num_bytes);
  assign w_on_bus = r_state inside {S_CMD_LOW, S_CMD_HIGH, S_TURN, S_RD_LOW, S_RD_HIGH};

  always_comb begin
    w_len = CNT_W'(1);
    case (r_state)
      S_CMD_LOW:  w_len = CNT_W'(WR_LOW_CYC);
      S_CMD_HIGH: w_len = CNT_W'(WR_HIGH_CYC);
      S_RD_LOW:   w_len = CNT_W'(RD_LOW_CYC);
      S_RD_HIGH:  w_len = CNT_W'(RD_HIGH_CYC);
      default:    w_len = CNT_W'(1);
    endcase
  end

  assign w_last = (r_cnt == w_len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_abort     = 1'b0;
    w_capture   = 1'b0;
    w_left_next = r_left;
    case (r_state)
      S_IDLE:     if (lcd.start) w_next = S_REQ;
      S_REQ:      if (lcd.bus_grant) w_next = S_CMD_LOW;
      S_CMD_LOW:  if (w_last) w_next = S_CMD_HIGH;
      S_CMD_HIGH: if (w_last) w_next = (r_left == '0) ? S_DONE : S_TURN;
      S_TURN:     w_next = S_RD_LOW;
      S_RD_LOW: begin
        if (w_last) begin
          w_next    = S_RD_HIGH;
          w_capture = 1'b1;
        end
      end
      S_RD_HIGH: begin
        if (w_last) begin
          w_left_next = r_left - LEFT_W'(1);
          w_next      = (r_left == LEFT_W'(1)) ? S_DONE : S_RD_LOW;
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    // Losing the bus mid-transfer overrides everything, including a pending capture.
    if (w_on_bus && !lcd.bus_grant) begin
      w_abort     = 1'b1;
      w_capture   = 1'b0;
      w_left_next = r_left;
      w_next      = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_cmd <= lcd.cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_left    <= '0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bus_req <= 1'b0;
      r_wr      <= 1'b1;
      r_rd      <= 1'b1;
      r_d_c     <= 1'b1;
      r_oe      <= 1'b0;
      r_db_out  <= '0;
    end else begin
      r_cnt  <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_left <= w_accept ? w_nb : w_left_next;
      if (w_accept)       r_rd_data <= '0;
      else if (w_capture) r_rd_data <= {r_rd_data[23:0], lcd.lcd_db_in};
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_err     <= w_abort;
      r_bus_req <= w_next inside {S_REQ, S_CMD_LOW, S_CMD_HIGH, S_TURN, S_RD_LOW, S_RD_HIGH};
      r_wr      <= (w_next != S_CMD_LOW);
      r_rd      <= (w_next != S_RD_LOW);
      r_d_c     <= !(w_next inside {S_CMD_LOW, S_CMD_HIGH});
      r_oe      <= w_next inside {S_CMD_LOW, S_CMD_HIGH};
      r_db_out  <= (w_next inside {S_CMD_LOW, S_CMD_HIGH}) ? r_cmd : 8'h00;
    end
  end

  assign lcd.busy       = r_busy;
  assign lcd.done       = r_done;
  assign lcd.err        = r_err;
  assign lcd.rd_data    = r_rd_data;
  assign lcd.bus_req    = r_bus_req;
  assign lcd.lcd_wr     = r_wr;
  assign lcd.lcd_rd     = r_rd;
  assign lcd.lcd_d_c    = r_d_c;
  assign lcd.lcd_db_oe  = r_oe;
  assign lcd.lcd_db_out = r_db_out;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: expected transaction results are queued at
// launch and compared when the reader pulses done.
module tb_lcd_bus_reader;

  localparam int RDL = 10;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          rdp;
    logic        rdok;
    int          wrp;
    int          oep;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  lcd_bus_reader_if bif();

  lcd_bus_reader dut (.clk(clk), .reset(reset), .lcd(bif));

  always #20 clk = ~clk;

  int   cyc = 0;
  int   t0 = 0;
  int   txn_id = 0;
  logic [7:0] cur_cmd = 8'h00;
  logic [7:0] bytes_a [4];
  exp_t sb [$];
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Panel model: presents the next byte when RD falls.
  logic [7:0] db_in_r = 8'h00;
  int   bm_id = 0;
  int   bm_idx = 0;
  assign bif.lcd_db_in = db_in_r;
  always @(negedge bif.lcd_rd) begin
    if (bm_id != txn_id) begin bm_id = txn_id; bm_idx = 0; end
    db_in_r = (bm_idx < 4) ? bytes_a[bm_idx] : 8'h00;
    bm_idx++;
  end

  // Bus observer: per-transaction pulse statistics and a snapshot at done.
  int   m_id = 0, rd_run = 0, wr_run = 0, rdp = 0, wrp = 0, oep = 0, n_done = 0;
  logic rd_ok = 1'b1, wr_bad = 1'b0, wr_nogrant = 1'b0;
  logic [31:0] s_data;
  logic        s_err;
  int          s_cyc;
  logic [13:0] s_lines;
  always @(negedge clk) begin
    if (txn_id != m_id) begin
      m_id = txn_id; rdp = 0; wrp = 0; oep = 0;
      rd_ok = 1'b1; wr_bad = 1'b0; wr_nogrant = 1'b0;
    end
    if (reset) begin
      rd_run = 0; wr_run = 0;
    end else begin
      if (!bif.lcd_rd) rd_run++;
      else if (rd_run != 0) begin
        rdp++;
        if (rd_run != RDL) rd_ok = 1'b0;
        rd_run = 0;
      end
      if (!bif.lcd_wr) wr_run++;
      else if (wr_run != 0) begin
        wrp++;
        if (wr_run != 2) wr_bad = 1'b1;
        wr_run = 0;
      end
      if (bif.lcd_db_oe) begin
        oep++;
        if (bif.lcd_db_out !== cur_cmd || bif.lcd_d_c !== 1'b0) wr_bad = 1'b1;
      end
      if (!bif.lcd_wr && !bif.lcd_db_oe) wr_bad = 1'b1;
      if (!bif.lcd_wr && !bif.bus_grant) wr_nogrant = 1'b1;
      if (bif.done) begin
        n_done++;
        s_data  = bif.rd_data;
        s_err   = bif.err;
        s_cyc   = cyc - t0;
        s_lines = {bif.lcd_wr, bif.lcd_rd, bif.lcd_d_c, bif.lcd_db_oe,
                   bif.lcd_db_out, bif.bus_req, bif.busy};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int n);
    logic [31:0] d = '0;
    for (int i = 0; i < n; i++) d = {d[23:0], bytes_a[i]};
    return d;
  endfunction

  function automatic int done_cyc(input int n, input int delay);
    return (n == 0) ? 6 + delay : 7 + 14 * n + delay;
  endfunction

  task automatic push_exp(input int n, input int delay);
    exp_t e;
    e.data = pack(n); e.err = 1'b0; e.cyc = done_cyc(n, delay);
    e.rdp = n; e.rdok = 1'b1; e.wrp = 1; e.oep = 4;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [7:0] c, input logic [2:0] n);
    @(posedge clk); #1;
    txn_id++;
    cur_cmd = c;
    bif.cmd = c; bif.num_bytes = n; bif.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bif.start = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc - t0 < k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_and_score(input string tag);
    exp_t e;
    int   target = n_done + 1;
    int   k = 0;
    while (n_done < target && k < 300) begin @(posedge clk); #1; k++; end
    chk({tag, "_done_seen"}, n_done, target);
    if (n_done >= target && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rd_data"}, s_data, e.data);
      chk({tag, "_err"}, s_err, e.err);
      chk({tag, "_done_cyc"}, s_cyc, e.cyc);
      chk({tag, "_rd_pulses"}, rdp, e.rdp);
      chk({tag, "_rd_width"}, rd_ok, e.rdok);
      chk({tag, "_wr_pulses"}, wrp, e.wrp);
      chk({tag, "_oe_cycles"}, oep, e.oep);
      chk({tag, "_wr_phase_bad"}, wr_bad, 1'b0);
      chk({tag, "_done_lines"}, s_lines, {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lines"},
        {bif.lcd_wr, bif.lcd_rd, bif.lcd_d_c, bif.lcd_db_oe, bif.lcd_db_out,
         bif.bus_req, bif.busy, bif.done, bif.err},
        {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    chk({tag, "_rd_data"}, bif.rd_data, 32'h0);
  endtask

  initial begin
    exp_t e;
    int   saved;
    logic seen;
    reset = 1'b1;
    bif.start = 1'b0; bif.cmd = 8'h00; bif.num_bytes = 3'd0; bif.bus_grant = 1'b1;
    for (int i = 0; i < 4; i++) bytes_a[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // ID read, four bytes, with a start pulse while busy that must be ignored.
    bytes_a[0] = 8'h00; bytes_a[1] = 8'h85; bytes_a[2] = 8'h85; bytes_a[3] = 8'h52;
    push_exp(4, 0);
    launch(8'h04, 3'd4);
    wait_cyc(10);
    bif.start = 1'b1; @(posedge clk); #1; bif.start = 1'b0;
    wait_and_score("id4");
    repeat (3) @(posedge clk);
    #1 chk("id4_no_relaunch", bif.bus_req, 1'b0);

    // Command only.
    push_exp(0, 0);
    launch(8'h29, 3'd0);
    wait_and_score("cmd0");
    chk("cmd0_rd_data_zero", s_data, 32'h0);

    // Grant arrives five REQ cycles late.
    bif.bus_grant = 1'b0;
    bytes_a[0] = 8'h3C;
    push_exp(1, 5);
    launch(8'h0A, 3'd1);
    @(negedge clk);
    chk("late_bus_req", bif.bus_req, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    bif.bus_grant = 1'b1;
    wait_and_score("late");
    chk("late_wr_without_grant", wr_nogrant, 1'b0);

    // Grant lost during the second read strobe.
    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33;
    e.data = 32'h0000_0011; e.err = 1'b1; e.cyc = 25;
    e.rdp = 2; e.rdok = 1'b0; e.wrp = 1; e.oep = 4;
    sb.push_back(e);
    launch(8'hDA, 3'd3);
    wait_cyc(24);
    bif.bus_grant = 1'b0;
    wait_and_score("abort");
    @(posedge clk); #1;
    bif.bus_grant = 1'b1;

    // Reset in the middle of a read, after a start pulse during busy.
    bytes_a[0] = 8'hAA; bytes_a[1] = 8'hBB;
    saved = n_done;
    launch(8'h04, 3'd2);
    wait_cyc(3);
    bif.start = 1'b1; @(posedge clk); #1; bif.start = 1'b0;
    wait_cyc(25);
    chk("pre_reset_rd_data", bif.rd_data, 32'h0000_00AA);
    chk("pre_reset_rd_low", bif.lcd_rd, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset");
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bif.bus_req || bif.busy) seen = 1'b1;
    end
    chk("mid_reset_no_activity", seen, 1'b0);
    chk("mid_reset_no_done", n_done, saved);

    // Oversized byte count is clamped.
    bytes_a[0] = 8'h01; bytes_a[1] = 8'h02; bytes_a[2] = 8'h03; bytes_a[3] = 8'h04;
    push_exp(4, 0);
    launch(8'hDB, 3'd7);
    wait_and_score("clamp");

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
